// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and burst helpers for the bus arbiter.
//   trans_t    - address-phase transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   burst_t    - burst type (SINGLE, INCR, WRAP4 .. INCR16)
//   UndefLen   - beat-counter value marking an undefined-length burst
//   burstBeats - number of beats in a fixed-length burst, 0 for INCR
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } trans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } burst_t;

    localparam int BeatsWidth = 5;

    // Fixed bursts never leave more than 15 beats outstanding, so the
    // all-ones value cannot collide with a real count.
    localparam logic [BeatsWidth-1:0] UndefLen = 5'h1F;

    function automatic logic [BeatsWidth-1:0] burstBeats(burst_t b);
        case (b)
            SINGLE:         return 5'd1;
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req_i      - per-manager request vector
//   rr_ptr_i   - index of the last winner; search starts just after it
//   winner_o   - first requesting index found, wrapping modulo NumManagers
//   any_req_o  - at least one request is set (winner_o valid)
module rr_picker #(
    parameter  int NumManagers = 4,
    localparam int SelWidth    = $clog2(NumManagers)
) (
    input  logic [NumManagers-1:0] req_i,
    input  logic [SelWidth-1:0]    rr_ptr_i,
    output logic [SelWidth-1:0]    winner_o,
    output logic                   any_req_o
);

    logic [SelWidth-1:0] pick;

    // Walk from the farthest offset to the nearest so that the nearest
    // requester after the pointer is the last (and final) assignment.
    // Offset NumManagers is the pointer itself, which is therefore eligible last.
    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        pick      = '0;
        for (int i = NumManagers; i >= 1; i--) begin
            pick = SelWidth'((int'(rr_ptr_i) + i) % NumManagers);
            if (req_i[pick]) begin
                winner_o  = pick;
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter driving the manager-side muxes.
//   clk, nReset - bus clock, asynchronous active-low reset
//   req         - per-manager level-sensitive bus requests
//   trans/burst/mastLock - muxed address-phase controls of the current owner
//   ready       - bus ready; an edge with ready=1 accepts the current
//                 address phase. All state advances only on such edges and
//                 holds (wait states) otherwise.
//   grant       - one-hot address-phase owner
//   addrSel     - index of the address-phase owner (address/control mux)
//   dataSel     - index of the data-phase owner, one accepted phase behind
//   locked      - current tenure is locked, arbitration frozen
module ahb_arbiter #(
    parameter  int NumManagers    = 4,
    parameter  int DefaultManager = 0,
    localparam int SelWidth       = $clog2(NumManagers)
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [NumManagers-1:0] req,
    input  logic [1:0]             trans,
    input  logic [2:0]             burst,
    input  logic                   mastLock,
    input  logic                   ready,
    output logic [NumManagers-1:0] grant,
    output logic [SelWidth-1:0]    addrSel,
    output logic [SelWidth-1:0]    dataSel,
    output logic                   locked
);

    import ahb_pkg::*;

    localparam logic [SelWidth-1:0]    DefSel   = SelWidth'(DefaultManager);
    localparam logic [NumManagers-1:0] DefGrant =
        {{(NumManagers-1){1'b0}}, 1'b1} << DefaultManager;

    trans_t trans_s;
    burst_t burst_s;

    logic [NumManagers-1:0] grant_q, grant_d;
    logic [SelWidth-1:0]    addr_sel_q, addr_sel_d;
    logic [SelWidth-1:0]    data_sel_q;
    logic [SelWidth-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BeatsWidth-1:0]  beats_left_q, beats_left_d;
    logic                   locked_q;
    logic                   end_t;
    logic [SelWidth-1:0]    winner;
    logic                   any_req;

    assign trans_s = trans_t'(trans);
    assign burst_s = burst_t'(burst);

    rr_picker #(
        .NumManagers (NumManagers)
    ) u_rr_picker (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Beats still outstanding after the phase being accepted.
    always_comb begin
        beats_left_d = beats_left_q;
        case (trans_s)
            NONSEQ: begin
                if (burst_s == INCR) beats_left_d = UndefLen;
                else                 beats_left_d = burstBeats(burst_s) - 5'd1;
            end
            SEQ: begin
                // A SEQ with nothing outstanding is a continuation we cannot
                // bound, so it becomes undefined-length and never ends a tenure.
                if (beats_left_q == UndefLen || beats_left_q == '0)
                    beats_left_d = UndefLen;
                else
                    beats_left_d = beats_left_q - 5'd1;
            end
            default: beats_left_d = beats_left_q;
        endcase
    end

    // beats_left_q == 1 can only hold on a fixed-length burst.
    assign end_t = ready && !mastLock &&
                   ((trans_s == IDLE) ||
                    (trans_s == NONSEQ && burst_s == SINGLE) ||
                    (trans_s == SEQ && beats_left_q == 5'd1));

    always_comb begin
        addr_sel_d = addr_sel_q;
        rr_ptr_d   = rr_ptr_q;
        if (end_t) begin
            if (any_req) begin
                addr_sel_d = winner;
                rr_ptr_d   = winner;
            end else begin
                addr_sel_d = DefSel;
            end
        end
        grant_d             = '0;
        grant_d[addr_sel_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            grant_q      <= DefGrant;
            addr_sel_q   <= DefSel;
            data_sel_q   <= DefSel;
            rr_ptr_q     <= DefSel;
            beats_left_q <= '0;
            locked_q     <= 1'b0;
        end else if (ready) begin
            grant_q      <= grant_d;
            addr_sel_q   <= addr_sel_d;
            data_sel_q   <= addr_sel_q;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
            locked_q     <= mastLock;
        end
    end

    // grant is registered directly so a re-grant to the same owner
    // cannot glitch through a decoder.
    assign grant   = grant_q;
    assign addrSel = addr_sel_q;
    assign dataSel = data_sel_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: scenario tasks for the round-robin AHB arbiter with a
// reference model feeding an expected-output queue.
module tb_ahb_arbiter;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       nReset;
    logic [3:0] req;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       mastLock;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] addrSel;
    logic [1:0] dataSel;
    logic       locked;

    always #5 clk = ~clk;

    ahb_arbiter #(
        .NumManagers    (4),
        .DefaultManager (0)
    ) dut (
        .clk      (clk),
        .nReset   (nReset),
        .req      (req),
        .trans    (trans),
        .burst    (burst),
        .mastLock (mastLock),
        .ready    (ready),
        .grant    (grant),
        .addrSel  (addrSel),
        .dataSel  (dataSel),
        .locked   (locked)
    );

    // ---------------- scoreboard / model ----------------
    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];

    int   m_owner;
    int   m_ptr;
    int   m_rem;     // -1 = undefined length
    int   m_data;
    logic m_lock;

    typedef struct packed {
        logic [1:0] t;
        logic [2:0] b;
        logic       lk;
        logic       rdy;
        logic [3:0] rq;
        logic [3:0] g;     // grant expected after this edge
    } vec_t;

    function automatic int model_beats(logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_ptr   = 0;
        m_rem   = 0;
        m_data  = 0;
        m_lock  = 1'b0;
    endtask

    function automatic logic [8:0] model_out();
        logic [3:0] g;
        g = 4'b0001 << m_owner;
        return {g, 2'(m_owner), 2'(m_data), m_lock};
    endfunction

    task automatic model_step(input logic [1:0] t, input logic [2:0] b,
                              input logic lk, input logic [3:0] rq);
        bit fin;
        int win;
        int idx;
        fin = !lk && (t == 2'b00 || (t == 2'b10 && b == 3'b000) ||
                      (t == 2'b11 && m_rem == 1));
        m_data = m_owner;
        m_lock = lk;
        if (t == 2'b10)      m_rem = (b == 3'b001) ? -1 : model_beats(b) - 1;
        else if (t == 2'b11) m_rem = (m_rem <= 0) ? -1 : m_rem - 1;
        if (fin) begin
            win = -1;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (win < 0 && rq[idx]) win = idx;
            end
            if (win < 0) m_owner = 0;
            else begin
                m_owner = win;
                m_ptr   = win;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [1:0] t, input logic [2:0] b,
                         input logic lk, input logic rdy, input logic [3:0] rq);
        trans    = t;
        burst    = b;
        mastLock = lk;
        ready    = rdy;
        req      = rq;
        if (rdy) model_step(t, b, lk, rq);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        vec_t       tbl [0:2];
        logic [8:0] exp;
        nReset   = 1'b0;
        req      = '0;
        trans    = 2'b00;
        burst    = 3'b000;
        mastLock = 1'b0;
        ready    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({grant, addrSel, dataSel, locked} !== {4'b0001, 2'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got=%b exp=%b",
                     {grant, addrSel, dataSel, locked}, {4'b0001, 2'd0, 2'd0, 1'b0});
        end
        nReset = 1'b1;
        // bring owner 2 in and start an INCR4
        tbl = '{ {2'b00, 3'b000, 1'b0, 1'b1, 4'b0100, 4'b0100},
                 {2'b10, 3'b011, 1'b0, 1'b1, 4'b0100, 4'b0100},
                 {2'b11, 3'b011, 1'b0, 1'b1, 4'b0100, 4'b0100} };
        foreach (tbl[i]) begin
            drive(tbl[i].t, tbl[i].b, tbl[i].lk, tbl[i].rdy, tbl[i].rq);
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp) begin
                miscompares++;
                $display("FAIL pre_reset_model[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
            vectors++;
            if (grant !== tbl[i].g) begin
                miscompares++;
                $display("FAIL pre_reset_grant[%0d] got=%b exp=%b", i, grant, tbl[i].g);
            end
        end
        // asynchronous reset mid-burst, checked before any clock edge
        #2 nReset = 1'b0;
        #1;
        vectors++;
        if ({grant, addrSel, dataSel, locked} !== {4'b0001, 2'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset got=%b exp=%b",
                     {grant, addrSel, dataSel, locked}, {4'b0001, 2'd0, 2'd0, 1'b0});
        end
        model_reset();
        trans = 2'b00;
        req   = '0;
        @(posedge clk);
        #1 nReset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 3'b000, 1'b0, 1'b1, 4'b0000);
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp ||
                grant !== 4'b0001) begin
                miscompares++;
                $display("FAIL idle_default[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gseq [0:4];
        logic [8:0] exp;
        logic [1:0] prev_addr;
        gseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            prev_addr = addrSel;
            drive(2'b10, 3'b000, 1'b0, 1'b1, 4'b1111);
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp) begin
                miscompares++;
                $display("FAIL rr_model[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
            vectors++;
            if (grant !== gseq[i]) begin
                miscompares++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, gseq[i]);
            end
            vectors++;
            if (dataSel !== prev_addr) begin
                miscompares++;
                $display("FAIL rr_datasel_trail[%0d] got=%0d exp=%0d", i, dataSel, prev_addr);
            end
        end
    endtask

    task automatic test_fixed_burst();
        vec_t       tbl [0:6];
        logic [8:0] exp;
        tbl = '{ {2'b10, 3'b011, 1'b0, 1'b1, 4'b1010, 4'b0010},
                 {2'b11, 3'b011, 1'b0, 1'b0, 4'b1010, 4'b0010},
                 {2'b11, 3'b011, 1'b0, 1'b0, 4'b1010, 4'b0010},
                 {2'b11, 3'b011, 1'b0, 1'b1, 4'b1010, 4'b0010},
                 {2'b01, 3'b011, 1'b0, 1'b1, 4'b1010, 4'b0010},
                 {2'b11, 3'b011, 1'b0, 1'b1, 4'b1010, 4'b0010},
                 {2'b11, 3'b011, 1'b0, 1'b1, 4'b1010, 4'b1000} };
        foreach (tbl[i]) begin
            drive(tbl[i].t, tbl[i].b, tbl[i].lk, tbl[i].rdy, tbl[i].rq);
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp) begin
                miscompares++;
                $display("FAIL burst_model[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
            vectors++;
            if (grant !== tbl[i].g) begin
                miscompares++;
                $display("FAIL burst_grant[%0d] got=%b exp=%b", i, grant, tbl[i].g);
            end
        end
    endtask

    task automatic test_undefined_incr();
        vec_t       tbl [0:8];
        logic [8:0] exp;
        tbl[0] = {2'b00, 3'b000, 1'b0, 1'b1, 4'b0100, 4'b0100};
        tbl[1] = {2'b10, 3'b001, 1'b0, 1'b1, 4'b1111, 4'b0100};
        for (int k = 2; k < 8; k++) tbl[k] = {2'b11, 3'b001, 1'b0, 1'b1, 4'b1111, 4'b0100};
        tbl[8] = {2'b00, 3'b000, 1'b0, 1'b1, 4'b1111, 4'b1000};
        foreach (tbl[i]) begin
            drive(tbl[i].t, tbl[i].b, tbl[i].lk, tbl[i].rdy, tbl[i].rq);
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp) begin
                miscompares++;
                $display("FAIL incr_model[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
            vectors++;
            if (grant !== tbl[i].g) begin
                miscompares++;
                $display("FAIL incr_grant[%0d] got=%b exp=%b", i, grant, tbl[i].g);
            end
        end
    endtask

    task automatic test_locked();
        vec_t       tbl [0:5];
        logic [0:5] lk_exp;
        logic [8:0] exp;
        tbl = '{ {2'b00, 3'b000, 1'b0, 1'b1, 4'b0001, 4'b0001},
                 {2'b10, 3'b000, 1'b1, 1'b1, 4'b1111, 4'b0001},
                 {2'b00, 3'b000, 1'b1, 1'b1, 4'b1111, 4'b0001},
                 {2'b00, 3'b000, 1'b1, 1'b0, 4'b1111, 4'b0001},
                 {2'b10, 3'b000, 1'b1, 1'b1, 4'b1111, 4'b0001},
                 {2'b00, 3'b000, 1'b0, 1'b1, 4'b1111, 4'b0010} };
        lk_exp = 6'b011110;
        foreach (tbl[i]) begin
            drive(tbl[i].t, tbl[i].b, tbl[i].lk, tbl[i].rdy, tbl[i].rq);
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp) begin
                miscompares++;
                $display("FAIL lock_model[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
            vectors++;
            if (grant !== tbl[i].g || locked !== lk_exp[i]) begin
                miscompares++;
                $display("FAIL lock_grant[%0d] got=%b/%b exp=%b/%b", i,
                         grant, locked, tbl[i].g, lk_exp[i]);
            end
        end
    endtask

    task automatic test_early_term();
        vec_t       tbl [0:4];
        logic [8:0] exp;
        tbl = '{ {2'b00, 3'b000, 1'b0, 1'b1, 4'b1000, 4'b1000},
                 {2'b10, 3'b100, 1'b0, 1'b1, 4'b1111, 4'b1000},
                 {2'b11, 3'b100, 1'b0, 1'b1, 4'b1111, 4'b1000},
                 {2'b11, 3'b100, 1'b0, 1'b1, 4'b1111, 4'b1000},
                 {2'b10, 3'b000, 1'b0, 1'b1, 4'b1111, 4'b0001} };
        foreach (tbl[i]) begin
            drive(tbl[i].t, tbl[i].b, tbl[i].lk, tbl[i].rdy, tbl[i].rq);
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp) begin
                miscompares++;
                $display("FAIL early_model[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
            vectors++;
            if (grant !== tbl[i].g) begin
                miscompares++;
                $display("FAIL early_grant[%0d] got=%b exp=%b", i, grant, tbl[i].g);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] exp;
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)));
            exp = exp_q.pop_front();
            vectors++;
            if ({grant, addrSel, dataSel, locked} !== exp) begin
                miscompares++;
                $display("FAIL random[%0d] got=%b exp=%b", i,
                         {grant, addrSel, dataSel, locked}, exp);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_round_robin();
        test_fixed_burst();
        test_undefined_incr();
        test_locked();
        test_early_term();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
